music_rom_player: RTL and testbench

- Reader side of the song-select address range. Consumes the start_addr/end_addr pair produced by the song state controller.
- Walks a synchronous note ROM from start_addr to end_addr, one entry per beat, and presents the current note code to the tone generator.
- Restarts automatically when the selected range changes. Wraps or stops at end of song, depending on build option.

---
 rtl/music_rom_player_pkg.sv | 31 +++
 rtl/music_rom_player_if.sv | 32 +++
 rtl/music_rom_player_beat_counter.sv | 43 ++++
 rtl/music_rom_player.sv | 133 +++++++++++++
 tb/tb_music_rom_player.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/music_rom_player_pkg.sv
// ============================================================================
// music_pkg
//   State encoding, note constants and song ranges for the ROM song player.
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package music_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_NOTE_W = 8;

   localparam int NOTE_REST = 0;

   // Song ranges, shared with the song state controller
   localparam int SONG_A_START = 0;
   localparam int SONG_A_END   = 138;
   localparam int SONG_B_START = 139;
   localparam int SONG_B_END   = 335;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/music_rom_player_if.sv
// ============================================================================
// music_rom_player_if
//   Song range, ROM port and tone-generator outputs of the ROM song player.
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface music_rom_player_if #(
   parameter int ADDR_W = music_pkg::DEF_ADDR_W,
   parameter int NOTE_W = music_pkg::DEF_NOTE_W
);
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [NOTE_W-1:0] rom_data;
   logic [ADDR_W-1:0] rom_addr;
   logic [NOTE_W-1:0] note;
   logic              beat_pulse;
   logic              song_wrap;
   logic              busy;

   modport slave (
      input  start_addr, end_addr, rom_data,
      output rom_addr, note, beat_pulse, song_wrap, busy
   );

   modport master (
      output start_addr, end_addr, rom_data,
      input  rom_addr, note, beat_pulse, song_wrap, busy
   );
endinterface

`default_nettype wire

// File: rtl/music_rom_player_beat_counter.sv
// ============================================================================
// beat_counter
//   Loadable down-counter timing one beat; zero flags the last cycle of a beat.
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module beat_counter #(
   parameter int BEAT_DIV = 12500000,
   parameter int CNT_W    = 24
) (
   input  wire  clk,
   input  wire  rst_n,
   input  wire  load,
   input  wire  dec,
   output logic zero
);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BEAT_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/music_rom_player.sv
// ============================================================================
// music_rom_player
//   Walks the note ROM over the selected song range, one entry per beat.
//   MUSIC_PLAYER_LOOP_EN: defined = wrap to start forever, undefined = stop.
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module music_rom_player
   import music_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NOTE_W   = DEF_NOTE_W,
   parameter int BEAT_DIV = 12500000,
   parameter int CNT_W    = 24
) (
   input wire               clk,
   input wire               rst_n,
   music_rom_player_if.slave bus
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] s_lat_q, s_lat_d;
   logic [ADDR_W-1:0] e_lat_q, e_lat_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              beat_pulse_q, beat_pulse_d;
   logic              song_wrap_q, song_wrap_d;
   logic              busy_q, busy_d;
   logic              cnt_load, cnt_dec, cnt_zero, range_chg;

   beat_counter #(
      .BEAT_DIV (BEAT_DIV),
      .CNT_W    (CNT_W)
   ) u_beat_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .zero  (cnt_zero)
   );

   assign range_chg = (bus.start_addr != s_lat_q) || (bus.end_addr != e_lat_q);

   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      s_lat_d      = s_lat_q;
      e_lat_d      = e_lat_q;
      note_d       = note_q;
      beat_pulse_d = 1'b0;
      song_wrap_d  = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;

      // A new range aborts whatever is in flight, including a pending wrap
      if ((state_q != ST_IDLE) && range_chg) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               s_lat_d    = bus.start_addr;
               e_lat_d    = bus.end_addr;
               rom_addr_d = bus.start_addr;
               if (bus.start_addr <= bus.end_addr) begin
                  state_d = ST_FETCH;
               end else begin
                  note_d = NOTE_W'(NOTE_REST);
               end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
               note_d       = bus.rom_data;
               beat_pulse_d = 1'b1;
               cnt_load     = 1'b1;
               state_d      = ST_PLAY;
            end
            ST_PLAY: begin
               cnt_dec = 1'b1;
               if (cnt_zero) begin
                  if (rom_addr_q == e_lat_q) begin
                     song_wrap_d = 1'b1;
`ifdef MUSIC_PLAYER_LOOP_EN
                     rom_addr_d  = s_lat_q;
                     state_d     = ST_FETCH;
`else
                     note_d      = NOTE_W'(NOTE_REST);
                     state_d     = ST_DONE;
`endif
                  end else begin
                     rom_addr_d = rom_addr_q + ADDR_W'(1);
                     state_d    = ST_FETCH;
                  end
               end
            end
            ST_DONE:  note_d  = NOTE_W'(NOTE_REST);
            default:  state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_FETCH) || (state_d == ST_WAIT) || (state_d == ST_PLAY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rom_addr_q   <= '0;
         s_lat_q      <= '0;
         e_lat_q      <= '0;
         note_q       <= '0;
         beat_pulse_q <= 1'b0;
         song_wrap_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         s_lat_q      <= s_lat_d;
         e_lat_q      <= e_lat_d;
         note_q       <= note_d;
         beat_pulse_q <= beat_pulse_d;
         song_wrap_q  <= song_wrap_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.note       = note_q;
   assign bus.beat_pulse = beat_pulse_q;
   assign bus.song_wrap  = song_wrap_q;
   assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_music_rom_player.sv
// ============================================================================
// tb_music_rom_player
//   Directed bench for music_rom_player, BEAT_DIV=4, ROM data = addr[7:0].
//   Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_music_rom_player;
   import music_pkg::*;

`ifdef MUSIC_PLAYER_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   music_rom_player_if #(.ADDR_W(10), .NOTE_W(8)) bus ();

   always_ff @(posedge clk) bus.rom_data <= bus.rom_addr[7:0];

   music_rom_player #(
      .ADDR_W   (10),
      .NOTE_W   (8),
      .BEAT_DIV (4),
      .CNT_W    (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset with the given range applied, release just after an edge
   task automatic start_song(input int s, input int e);
      rst_n = 1'b0;
      bus.start_addr = 10'(s);
      bus.end_addr   = 10'(e);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start_addr = 10'd0;
      bus.end_addr   = 10'd2;
      step();
      step();
      n_checks++; if (bus.rom_addr !== 10'd0) $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr); else n_pass++;
      n_checks++; if (bus.note !== 8'd0) $display("FAIL reset_note: got %0d want 0", bus.note); else n_pass++;
      n_checks++; if (bus.beat_pulse !== 1'b0) $display("FAIL reset_beat_pulse: got %b want 0", bus.beat_pulse); else n_pass++;
      n_checks++; if (bus.song_wrap !== 1'b0) $display("FAIL reset_song_wrap: got %b want 0", bus.song_wrap); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
   endtask

   // Range 0..2: pulses every 6 cycles from cycle 3, wrap after the third beat
   task automatic test_sequence();
      logic exp_pulse, exp_wrap;
      int   idx;
      start_song(0, 2);
      for (int k = 1; k <= 30; k++) begin
         step();
         idx       = (k >= 3) ? (k - 3) / 6 : 0;
         exp_pulse = (k >= 3) && ((k - 3) % 6 == 0) && (LOOP || idx < 3);
         exp_wrap  = (k == 19);
         n_checks++; if (bus.beat_pulse !== exp_pulse) $display("FAIL seq_pulse@%0d: got %b want %b", k, bus.beat_pulse, exp_pulse); else n_pass++;
         n_checks++; if (bus.song_wrap !== exp_wrap) $display("FAIL seq_wrap@%0d: got %b want %b", k, bus.song_wrap, exp_wrap); else n_pass++;
         if (exp_pulse) begin
            n_checks++; if (bus.note !== 8'(idx % 3)) $display("FAIL seq_note@%0d: got %0d want %0d", k, bus.note, idx % 3); else n_pass++;
         end
         if (k == 20) begin
            n_checks++; if (bus.note !== (LOOP ? 8'd2 : 8'd0)) $display("FAIL seq_end_note: got %0d want %0d", bus.note, LOOP ? 2 : 0); else n_pass++;
            n_checks++; if (bus.busy !== LOOP) $display("FAIL seq_end_busy: got %b want %b", bus.busy, LOOP); else n_pass++;
            n_checks++; if (bus.rom_addr !== (LOOP ? 10'd0 : 10'd2)) $display("FAIL seq_end_addr: got %0d want %0d", bus.rom_addr, LOOP ? 0 : 2); else n_pass++;
         end
      end
   endtask

   // Switch song A -> song B while address 5 is playing
   task automatic test_range_switch();
      start_song(SONG_A_START, SONG_A_END);
      repeat (34) step();
      n_checks++; if (bus.note !== 8'd5) $display("FAIL sw_pre_note: got %0d want 5", bus.note); else n_pass++;
      bus.start_addr = 10'(SONG_B_START);
      bus.end_addr   = 10'(SONG_B_END);
      for (int e = 1; e <= 4; e++) begin
         step();
         n_checks++; if (bus.song_wrap !== 1'b0) $display("FAIL sw_wrap@%0d: got %b want 0", e, bus.song_wrap); else n_pass++;
         if (e == 1) begin
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL sw_idle_busy: got %b want 0", bus.busy); else n_pass++;
         end
         if (e == 2) begin
            n_checks++; if (bus.rom_addr !== 10'd139) $display("FAIL sw_rom_addr: got %0d want 139", bus.rom_addr); else n_pass++;
         end
         if (e < 4) begin
            n_checks++; if (bus.note !== 8'd5) $display("FAIL sw_hold_note@%0d: got %0d want 5", e, bus.note); else n_pass++;
         end else begin
            n_checks++; if (bus.note !== 8'd139) $display("FAIL sw_new_note: got %0d want 139", bus.note); else n_pass++;
            n_checks++; if (bus.beat_pulse !== 1'b1) $display("FAIL sw_new_pulse: got %b want 1", bus.beat_pulse); else n_pass++;
         end
      end
   endtask

   task automatic test_single_entry();
      logic exp_pulse, exp_wrap;
      start_song(7, 7);
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_pulse = (k >= 3) && ((k - 3) % 6 == 0) && (LOOP || k == 3);
         exp_wrap  = (k >= 7) && ((k - 7) % 6 == 0) && (LOOP || k == 7);
         n_checks++; if (bus.beat_pulse !== exp_pulse) $display("FAIL one_pulse@%0d: got %b want %b", k, bus.beat_pulse, exp_pulse); else n_pass++;
         n_checks++; if (bus.song_wrap !== exp_wrap) $display("FAIL one_wrap@%0d: got %b want %b", k, bus.song_wrap, exp_wrap); else n_pass++;
         if (exp_pulse) begin
            n_checks++; if (bus.note !== 8'd7) $display("FAIL one_note@%0d: got %0d want 7", k, bus.note); else n_pass++;
         end
      end
   endtask

   task automatic test_invalid_range();
      start_song(10, 3);
      repeat (4) step();
      n_checks++; if (bus.note !== 8'd0) $display("FAIL inv_note: got %0d want 0", bus.note); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL inv_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++; if (bus.rom_addr !== 10'd10) $display("FAIL inv_rom_addr: got %0d want 10", bus.rom_addr); else n_pass++;
      n_checks++; if (bus.beat_pulse !== 1'b0) $display("FAIL inv_pulse: got %b want 0", bus.beat_pulse); else n_pass++;
      bus.end_addr = 10'd12;
      step();
      n_checks++; if (bus.busy !== 1'b1) $display("FAIL inv_start_busy: got %b want 1", bus.busy); else n_pass++;
      step();
      step();
      n_checks++; if (bus.note !== 8'd10) $display("FAIL inv_start_note: got %0d want 10", bus.note); else n_pass++;
      n_checks++; if (bus.beat_pulse !== 1'b1) $display("FAIL inv_start_pulse: got %b want 1", bus.beat_pulse); else n_pass++;
   endtask

   // Range 0..1 to the end of song, then a new range restarts playback
   task automatic test_done_restart();
      int wraps = 0;
      start_song(0, 1);
      for (int k = 1; k <= 25; k++) begin
         step();
         if (bus.song_wrap === 1'b1) wraps++;
      end
      n_checks++; if (wraps !== (LOOP ? 2 : 1)) $display("FAIL done_wraps: got %0d want %0d", wraps, LOOP ? 2 : 1); else n_pass++;
      n_checks++; if (bus.note !== (LOOP ? 8'd1 : 8'd0)) $display("FAIL done_note: got %0d want %0d", bus.note, LOOP ? 1 : 0); else n_pass++;
      n_checks++; if (bus.busy !== LOOP) $display("FAIL done_busy: got %b want %b", bus.busy, LOOP); else n_pass++;
      n_checks++; if (bus.rom_addr !== (LOOP ? 10'd0 : 10'd1)) $display("FAIL done_rom_addr: got %0d want %0d", bus.rom_addr, LOOP ? 0 : 1); else n_pass++;
      bus.start_addr = 10'd2;
      bus.end_addr   = 10'd3;
      repeat (4) step();
      n_checks++; if (bus.note !== 8'd2) $display("FAIL done_restart_note: got %0d want 2", bus.note); else n_pass++;
      n_checks++; if (bus.beat_pulse !== 1'b1) $display("FAIL done_restart_pulse: got %b want 1", bus.beat_pulse); else n_pass++;
   endtask

   task automatic test_reset_mid_song();
      start_song(0, 5);
      repeat (22) step();
      n_checks++; if (bus.note !== 8'd3) $display("FAIL rst_pre_note: got %0d want 3", bus.note); else n_pass++;
      rst_n = 1'b0;
      bus.start_addr = 10'd2;
      #1;
      n_checks++; if (bus.rom_addr !== 10'd0) $display("FAIL rst_async_addr: got %0d want 0", bus.rom_addr); else n_pass++;
      n_checks++; if (bus.note !== 8'd0) $display("FAIL rst_async_note: got %0d want 0", bus.note); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", bus.busy); else n_pass++;
      n_checks++; if (bus.beat_pulse !== 1'b0) $display("FAIL rst_async_pulse: got %b want 0", bus.beat_pulse); else n_pass++;
      n_checks++; if (bus.song_wrap !== 1'b0) $display("FAIL rst_async_wrap: got %b want 0", bus.song_wrap); else n_pass++;
      step();
      step();
      rst_n = 1'b1;
      step();
      n_checks++; if (bus.rom_addr !== 10'd2) $display("FAIL rst_restart_addr: got %0d want 2", bus.rom_addr); else n_pass++;
      step();
      step();
      n_checks++; if (bus.note !== 8'd2) $display("FAIL rst_restart_note: got %0d want 2", bus.note); else n_pass++;
      n_checks++; if (bus.beat_pulse !== 1'b1) $display("FAIL rst_restart_pulse: got %b want 1", bus.beat_pulse); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_range_switch();
      test_single_entry();
      test_invalid_range();
      test_done_restart();
      test_reset_mid_song();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
